// File: rtl/apb_cmd_sequencer.sv
// apb_cmd_sequencer: queues register write/read commands and issues them one at a
// time as an APB master, returning one response per command in order.
// Optional feature: define APB_SEQ_TIMEOUT_EN to abort ACCESS phases that see no
// PREADY within TIMEOUT_CYCLES cycles (response flagged with rsp_err).
module apb_cmd_sequencer #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int CNT_W         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PWRITE,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  output logic                  busy,
  output logic [CNT_W-1:0]      fifo_count
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

  cmd_t             mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push, pop, load, done;
  cmd_t             head;

  state_e                state_q, state_d;
  logic                  psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  rsp_valid_q, rsp_valid_d, rsp_write_q, rsp_write_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
`ifdef APB_SEQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic             rsp_err_q, rsp_err_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

  // Full blocks a push even when the FSM pops in the same cycle.
  assign cmd_ready  = (cnt_q != CNT_W'(FIFO_DEPTH));
  assign push       = cmd_valid && cmd_ready;
  assign head       = mem_q[rptr_q];
  assign fifo_count = cnt_q;
  assign busy       = (state_q != IDLE) || (cnt_q != '0);

  // FIFO occupancy follows push/pop; both in one cycle leaves it unchanged.
  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // FIFO storage; contents need no reset since pointers gate every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= {cmd_write, cmd_addr, cmd_wdata};
  end

  // FIFO pointers and count; pointer width makes wrap modulo FIFO_DEPTH.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PTR_W'(1);
      if (pop)  rptr_q <= rptr_q + PTR_W'(1);
      cnt_q <= cnt_d;
    end
  end

  // Next state and next registered outputs for the APB transfer sequence.
  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    load        = 1'b0;
    done        = 1'b0;
    psel_d      = psel_q;
    penable_d   = penable_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
`ifdef APB_SEQ_TIMEOUT_EN
    rsp_err_d   = rsp_err_q;
    tmo_d       = tmo_q;
`endif
    case (state_q)
      IDLE:  if (cnt_q != '0) load = 1'b1;
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
`ifdef APB_SEQ_TIMEOUT_EN
        tmo_d     = '0;
`endif
      end
      ACCESS: begin
        if (PREADY) begin
          done        = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : PRDATA;
`ifdef APB_SEQ_TIMEOUT_EN
          rsp_err_d   = 1'b0;
        end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          done        = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
`endif
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_write_d = 1'b0;
          rsp_rdata_d = '0;
`ifdef APB_SEQ_TIMEOUT_EN
          rsp_err_d   = 1'b0;
`endif
          // Go straight to the next transfer if one is queued.
          if (cnt_q != '0) load = 1'b1;
          else             state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (done) begin
      psel_d      = 1'b0;
      penable_d   = 1'b0;
      paddr_d     = '0;
      pwrite_d    = 1'b0;
      pwdata_d    = '0;
      rsp_valid_d = 1'b1;
      rsp_write_d = pwrite_q;
      state_d     = RESP;
    end
    if (load) begin
      pop       = 1'b1;
      psel_d    = 1'b1;
      penable_d = 1'b0;
      paddr_d   = head.addr;
      pwrite_d  = head.write;
      pwdata_d  = head.wdata;
      state_d   = SETUP;
    end
  end

  // State and output registers; reset drops any transfer and pending response.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef APB_SEQ_TIMEOUT_EN
      rsp_err_q   <= 1'b0;
      tmo_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef APB_SEQ_TIMEOUT_EN
      rsp_err_q   <= rsp_err_d;
      tmo_q       <= tmo_d;
`endif
    end
  end

  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PADDR     = paddr_q;
  assign PWRITE    = pwrite_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;
`ifdef APB_SEQ_TIMEOUT_EN
  assign rsp_err   = rsp_err_q;
`else
  assign rsp_err   = 1'b0;
`endif
endmodule
